mc_ctrl_hs: RTL and testbench



---
 rtl/mc_ctrl_hs_if.sv | 41 ++++
 rtl/mc_ctrl_hs.sv | 265 ++++++++++++++++++++++++++
 tb/tb_mc_ctrl_hs.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mc_ctrl_hs_if.sv
`default_nettype none
// ============================================================================
// Module   : mc_ctrl_hs_if
// Brief    : Controller <-> datapath/memory signal bundle for mc_ctrl_hs.
// Revision : 1.0 - initial release
// ============================================================================
interface mc_ctrl_hs_if #(
    parameter int ALUCTRL_W = 4
);
    logic [5:0]           op;
    logic [5:0]           funct;
    logic                 zero;
    logic                 mem_ready;
    logic                 mem_req;
    logic                 pcen;
    logic                 memwrite;
    logic                 irwrite;
    logic                 regwrite;
    logic                 alusrca;
    logic                 iord;
    logic                 zeroext;
    logic [1:0]           memtoreg;
    logic [1:0]           regdst;
    logic [1:0]           alusrcb;
    logic [1:0]           pcsrc;
    logic [ALUCTRL_W-1:0] alucontrol;
    logic                 fault;

    modport master (
        input  op, funct, zero, mem_ready,
        output mem_req, pcen, memwrite, irwrite, regwrite, alusrca, iord,
               zeroext, memtoreg, regdst, alusrcb, pcsrc, alucontrol, fault
    );

    modport slave (
        output op, funct, zero, mem_ready,
        input  mem_req, pcen, memwrite, irwrite, regwrite, alusrca, iord,
               zeroext, memtoreg, regdst, alusrcb, pcsrc, alucontrol, fault
    );
endinterface
`default_nettype wire

// File: rtl/mc_ctrl_hs.sv
`default_nettype none
// ============================================================================
// Module   : mc_ctrl_hs
// Brief    : Multicycle MIPS controller with memory handshake, timeout
//            watchdog and sticky FAULT. Define MC_CTRL_JAL_EN to decode JAL.
// Revision : 1.0 - initial release
// ============================================================================
module mc_ctrl_hs #(
    parameter int TIMEOUT   = 15,
    parameter int ALUCTRL_W = 4
) (
    input  wire logic     clk,
    input  wire logic     reset_n,
    mc_ctrl_hs_if.master  bus
);

    typedef enum logic [3:0] {
        ST_FETCH   = 4'd0,
        ST_DECODE  = 4'd1,
        ST_MEMADR  = 4'd2,
        ST_MEMRD   = 4'd3,
        ST_MEMWB   = 4'd4,
        ST_MEMWR   = 4'd5,
        ST_RTYPEEX = 4'd6,
        ST_RTYPEWB = 4'd7,
        ST_BREX    = 4'd8,
        ST_ADDIEX  = 4'd9,
        ST_IMMWB   = 4'd10,
        ST_JEX     = 4'd11,
        ST_ANDIEX  = 4'd12,
        ST_ORIEX   = 4'd13,
        ST_JALEX   = 4'd14,
        ST_FAULT   = 4'd15
    } state_t;

    localparam logic [5:0] c_OP_RTYPE = 6'b000000;
    localparam logic [5:0] c_OP_LW    = 6'b100011;
    localparam logic [5:0] c_OP_SW    = 6'b101011;
    localparam logic [5:0] c_OP_BEQ   = 6'b000100;
    localparam logic [5:0] c_OP_BNE   = 6'b000101;
    localparam logic [5:0] c_OP_ADDI  = 6'b001000;
    localparam logic [5:0] c_OP_ANDI  = 6'b001100;
    localparam logic [5:0] c_OP_ORI   = 6'b001101;
    localparam logic [5:0] c_OP_J     = 6'b000010;
`ifdef MC_CTRL_JAL_EN
    localparam logic [5:0] c_OP_JAL   = 6'b000011;
`endif

    localparam logic [5:0] c_FN_ADD = 6'b100000;
    localparam logic [5:0] c_FN_SUB = 6'b100010;
    localparam logic [5:0] c_FN_AND = 6'b100100;
    localparam logic [5:0] c_FN_OR  = 6'b100101;
    localparam logic [5:0] c_FN_SLT = 6'b101010;

    localparam logic [3:0] c_ALU_ADD = 4'b0000;
    localparam logic [3:0] c_ALU_SUB = 4'b0010;
    localparam logic [3:0] c_ALU_AND = 4'b0100;
    localparam logic [3:0] c_ALU_OR  = 4'b0101;
    localparam logic [3:0] c_ALU_SLT = 4'b1010;

    // TIMEOUT=0 would give a zero-width counter; keep one bit so it still elaborates.
    localparam int             c_CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [c_CNT_W-1:0] c_TMO = c_CNT_W'(TIMEOUT);

    state_t             r_state;
    state_t             w_next;
    logic [c_CNT_W-1:0] r_cnt;

    logic       w_memst;
    logic       w_timeout;
    logic       w_pcwrite;
    logic       w_branch;
    logic       w_bne;
    logic       w_mem_req;
    logic       w_memwrite;
    logic       w_irwrite;
    logic       w_regwrite;
    logic       w_alusrca;
    logic       w_iord;
    logic       w_zeroext;
    logic [1:0] w_memtoreg;
    logic [1:0] w_regdst;
    logic [1:0] w_alusrcb;
    logic [1:0] w_pcsrc;
    logic [3:0] w_aluctl;
    logic       w_fault;

    assign w_memst   = (r_state == ST_FETCH) || (r_state == ST_MEMRD) || (r_state == ST_MEMWR);
    assign w_timeout = (TIMEOUT != 0) && w_memst && !bus.mem_ready && (r_cnt == c_TMO);
    assign w_bne     = (bus.op == c_OP_BNE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    // Counter only runs while stalled inside one memory state; any move or completion restarts it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt <= '0;
        end else if (!w_memst || bus.mem_ready || (w_next != r_state)) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + c_CNT_W'(1);
        end
    end

    always_comb begin
        w_next     = r_state;
        w_mem_req  = 1'b0;
        w_pcwrite  = 1'b0;
        w_branch   = 1'b0;
        w_memwrite = 1'b0;
        w_irwrite  = 1'b0;
        w_regwrite = 1'b0;
        w_alusrca  = 1'b0;
        w_iord     = 1'b0;
        w_zeroext  = 1'b0;
        w_memtoreg = 2'd0;
        w_regdst   = 2'd0;
        w_alusrcb  = 2'd0;
        w_pcsrc    = 2'd0;
        w_aluctl   = c_ALU_ADD;
        w_fault    = 1'b0;

        case (r_state)
            ST_FETCH: begin
                w_mem_req = 1'b1;
                w_alusrcb = 2'd1;
                w_irwrite = bus.mem_ready;
                w_pcwrite = bus.mem_ready;
                if (bus.mem_ready) w_next = ST_DECODE;
            end
            ST_DECODE: begin
                w_alusrcb = 2'd3;
                case (bus.op)
                    c_OP_LW, c_OP_SW:   w_next = ST_MEMADR;
                    c_OP_RTYPE:         w_next = ST_RTYPEEX;
                    c_OP_BEQ, c_OP_BNE: w_next = ST_BREX;
                    c_OP_ADDI:          w_next = ST_ADDIEX;
                    c_OP_ANDI:          w_next = ST_ANDIEX;
                    c_OP_ORI:           w_next = ST_ORIEX;
                    c_OP_J:             w_next = ST_JEX;
`ifdef MC_CTRL_JAL_EN
                    c_OP_JAL:           w_next = ST_JALEX;
`endif
                    default:            w_next = ST_FAULT;
                endcase
            end
            ST_MEMADR: begin
                w_alusrca = 1'b1;
                w_alusrcb = 2'd2;
                w_next    = (bus.op == c_OP_SW) ? ST_MEMWR : ST_MEMRD;
            end
            ST_MEMRD: begin
                w_mem_req = 1'b1;
                w_iord    = 1'b1;
                if (bus.mem_ready) w_next = ST_MEMWB;
            end
            ST_MEMWB: begin
                w_regwrite = 1'b1;
                w_memtoreg = 2'd1;
                w_next     = ST_FETCH;
            end
            ST_MEMWR: begin
                w_mem_req  = 1'b1;
                w_iord     = 1'b1;
                w_memwrite = 1'b1;
                if (bus.mem_ready) w_next = ST_FETCH;
            end
            ST_RTYPEEX: begin
                w_alusrca = 1'b1;
                w_next    = ST_RTYPEWB;
                case (bus.funct)
                    c_FN_ADD: w_aluctl = c_ALU_ADD;
                    c_FN_SUB: w_aluctl = c_ALU_SUB;
                    c_FN_AND: w_aluctl = c_ALU_AND;
                    c_FN_OR:  w_aluctl = c_ALU_OR;
                    c_FN_SLT: w_aluctl = c_ALU_SLT;
                    default:  w_next   = ST_FAULT;
                endcase
            end
            ST_RTYPEWB: begin
                w_regwrite = 1'b1;
                w_regdst   = 2'd1;
                w_next     = ST_FETCH;
            end
            ST_BREX: begin
                w_alusrca = 1'b1;
                w_aluctl  = c_ALU_SUB;
                w_pcsrc   = 2'd1;
                w_branch  = 1'b1;
                w_next    = ST_FETCH;
            end
            ST_ADDIEX: begin
                w_alusrca = 1'b1;
                w_alusrcb = 2'd2;
                w_next    = ST_IMMWB;
            end
            ST_ANDIEX: begin
                w_alusrca = 1'b1;
                w_alusrcb = 2'd2;
                w_zeroext = 1'b1;
                w_aluctl  = c_ALU_AND;
                w_next    = ST_IMMWB;
            end
            ST_ORIEX: begin
                w_alusrca = 1'b1;
                w_alusrcb = 2'd2;
                w_zeroext = 1'b1;
                w_aluctl  = c_ALU_OR;
                w_next    = ST_IMMWB;
            end
            ST_IMMWB: begin
                w_regwrite = 1'b1;
                w_next     = ST_FETCH;
            end
            ST_JEX: begin
                w_pcsrc   = 2'd2;
                w_pcwrite = 1'b1;
                w_next    = ST_FETCH;
            end
`ifdef MC_CTRL_JAL_EN
            // PC already holds PC+4 here, so the link write takes the old PC value.
            ST_JALEX: begin
                w_regwrite = 1'b1;
                w_regdst   = 2'd2;
                w_memtoreg = 2'd2;
                w_pcsrc    = 2'd2;
                w_pcwrite  = 1'b1;
                w_next     = ST_FETCH;
            end
`endif
            ST_FAULT: begin
                w_fault = 1'b1;
                w_next  = ST_FAULT;
            end
            default: begin
                w_next = ST_FAULT;
            end
        endcase

        if (w_timeout) w_next = ST_FAULT;
    end

    assign bus.mem_req    = w_mem_req;
    assign bus.pcen       = w_pcwrite | (w_branch & (bus.zero ^ w_bne));
    assign bus.memwrite   = w_memwrite;
    assign bus.irwrite    = w_irwrite;
    assign bus.regwrite   = w_regwrite;
    assign bus.alusrca    = w_alusrca;
    assign bus.iord       = w_iord;
    assign bus.zeroext    = w_zeroext;
    assign bus.memtoreg   = w_memtoreg;
    assign bus.regdst     = w_regdst;
    assign bus.alusrcb    = w_alusrcb;
    assign bus.pcsrc      = w_pcsrc;
    assign bus.alucontrol = ALUCTRL_W'(w_aluctl);
    assign bus.fault      = w_fault;

endmodule
`default_nettype wire

// File: tb/tb_mc_ctrl_hs.sv
`default_nettype none
// ============================================================================
// Module   : tb_mc_ctrl_hs
// Brief    : Directed self-checking bench for mc_ctrl_hs (TIMEOUT=15).
// Revision : 1.0 - initial release
// ============================================================================
module tb_mc_ctrl_hs;

    logic clk;
    logic reset_n;
    int   n_tests;
    int   n_fail;

    mc_ctrl_hs_if #(.ALUCTRL_W(4)) bus();

    mc_ctrl_hs #(.TIMEOUT(15), .ALUCTRL_W(4)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    logic [3:0] st;
    assign st = dut.r_state;

    // {mem_req,pcen,memwrite,irwrite,regwrite,alusrca,iord,zeroext,memtoreg,regdst,alusrcb,pcsrc,alucontrol,fault}
    logic [20:0] outs;
    assign outs = {bus.mem_req, bus.pcen, bus.memwrite, bus.irwrite, bus.regwrite,
                   bus.alusrca, bus.iord, bus.zeroext, bus.memtoreg, bus.regdst,
                   bus.alusrcb, bus.pcsrc, bus.alucontrol, bus.fault};

    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_SW  = 6'b101011;
    localparam logic [5:0] OP_BEQ = 6'b000100;
    localparam logic [5:0] OP_BNE = 6'b000101;
    localparam logic [5:0] OP_ORI = 6'b001101;
    localparam logic [5:0] OP_J   = 6'b000010;
    localparam logic [5:0] OP_JAL = 6'b000011;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n       = 1'b0;
        bus.op        = 6'd0;
        bus.funct     = 6'd0;
        bus.zero      = 1'b0;
        bus.mem_ready = 1'b0;
        tick();
        reset_n = 1'b1;
    endtask

    // Completes FETCH with the given instruction; returns in DECODE.
    task automatic go_decode(input logic [5:0] o, input logic [5:0] f);
        bus.op        = o;
        bus.funct     = f;
        bus.mem_ready = 1'b1;
        tick();
        bus.mem_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b1;
        bus.op = 6'd0; bus.funct = 6'd0; bus.zero = 1'b0; bus.mem_ready = 1'b0;
        #1 reset_n = 1'b0;
        #2;
        n_tests++;
        if (st !== 4'd0) begin n_fail++; $display("FAIL reset_state: got %0d want 0", st); end
        n_tests++;
        if (outs !== {8'b1000_0000, 2'd0, 2'd0, 2'd1, 2'd0, 4'd0, 1'b0}) begin
            n_fail++; $display("FAIL reset_outputs: got %b want %b", outs,
                               {8'b1000_0000, 2'd0, 2'd0, 2'd1, 2'd0, 4'd0, 1'b0});
        end
        tick();
        reset_n = 1'b1;
    endtask

    task automatic test_reset_mid_write();
        do_reset();
        go_decode(OP_SW, 6'd0);
        tick();
        n_tests++;
        if (st !== 4'd2) begin n_fail++; $display("FAIL sw_memadr: got %0d want 2", st); end
        tick();
        tick();
        n_tests++;
        if ({st, bus.memwrite, bus.mem_req, bus.iord} !== {4'd5, 3'b111}) begin
            n_fail++; $display("FAIL sw_memwr_wait: got %h want %h", {st, bus.memwrite, bus.mem_req, bus.iord}, {4'd5, 3'b111});
        end
        #2 reset_n = 1'b0;
        #1;
        n_tests++;
        if ({st, bus.mem_req, bus.memwrite, bus.fault} !== {4'd0, 3'b100}) begin
            n_fail++; $display("FAIL async_reset_memwr: got %h want %h", {st, bus.mem_req, bus.memwrite, bus.fault}, {4'd0, 3'b100});
        end
        tick();
        reset_n       = 1'b1;
        bus.mem_ready = 1'b1;
        #1;
        n_tests++;
        if ({bus.irwrite, bus.pcen} !== 2'b11) begin
            n_fail++; $display("FAIL post_reset_fetch: got %b want 11", {bus.irwrite, bus.pcen});
        end
        @(posedge clk); #1;
        bus.mem_ready = 1'b0;
        n_tests++;
        if (st !== 4'd1) begin n_fail++; $display("FAIL post_reset_decode: got %0d want 1", st); end
    endtask

    localparam logic [3:0] LW_ST  [0:10] = '{4'd0, 4'd0, 4'd0, 4'd0, 4'd1, 4'd2, 4'd3, 4'd3, 4'd3, 4'd4, 4'd0};
    localparam logic       LW_RDY [0:10] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

    task automatic test_lw_wait();
        do_reset();
        bus.op = OP_LW;
        for (int i = 0; i < 11; i++) begin
            bus.mem_ready = LW_RDY[i];
            #1;
            n_tests++;
            if (st !== LW_ST[i]) begin n_fail++; $display("FAIL lw_state[%0d]: got %0d want %0d", i, st, LW_ST[i]); end
            n_tests++;
            if (bus.regwrite !== (LW_ST[i] == 4'd4)) begin
                n_fail++; $display("FAIL lw_regwrite[%0d]: got %b want %b", i, bus.regwrite, (LW_ST[i] == 4'd4));
            end
            if (LW_ST[i] == 4'd4) begin
                n_tests++;
                if (bus.memtoreg !== 2'd1) begin n_fail++; $display("FAIL lw_memtoreg: got %0d want 1", bus.memtoreg); end
            end
            tick();
        end
        bus.mem_ready = 1'b0;
    endtask

    task automatic test_branch();
        do_reset();
        go_decode(OP_BNE, 6'd0);
        bus.zero = 1'b0;
        tick();
        n_tests++;
        if ({st, bus.pcen, bus.pcsrc, bus.alucontrol} !== {4'd8, 1'b1, 2'd1, 4'b0010}) begin
            n_fail++; $display("FAIL bne_nz: got %h want %h", {st, bus.pcen, bus.pcsrc, bus.alucontrol}, {4'd8, 1'b1, 2'd1, 4'b0010});
        end
        tick();
        n_tests++;
        if (st !== 4'd0) begin n_fail++; $display("FAIL brex_to_fetch: got %0d want 0", st); end
        go_decode(OP_BEQ, 6'd0);
        tick();
        n_tests++;
        if ({st, bus.pcen, bus.alucontrol} !== {4'd8, 1'b0, 4'b0010}) begin
            n_fail++; $display("FAIL beq_nz: got %h want %h", {st, bus.pcen, bus.alucontrol}, {4'd8, 1'b0, 4'b0010});
        end
        bus.zero = 1'b1;
        #1;
        n_tests++;
        if (bus.pcen !== 1'b1) begin n_fail++; $display("FAIL beq_z: got %b want 1", bus.pcen); end
        bus.zero = 1'b0;
    endtask

    task automatic test_ori();
        do_reset();
        go_decode(OP_ORI, 6'd0);
        tick();
        n_tests++;
        if ({st, bus.zeroext, bus.alucontrol, bus.alusrcb} !== {4'd13, 1'b1, 4'b0101, 2'd2}) begin
            n_fail++; $display("FAIL ori_ex: got %h want %h", {st, bus.zeroext, bus.alucontrol, bus.alusrcb}, {4'd13, 1'b1, 4'b0101, 2'd2});
        end
        tick();
        n_tests++;
        if ({st, bus.regwrite, bus.regdst, bus.memtoreg} !== {4'd10, 1'b1, 2'd0, 2'd0}) begin
            n_fail++; $display("FAIL ori_wb: got %h want %h", {st, bus.regwrite, bus.regdst, bus.memtoreg}, {4'd10, 1'b1, 2'd0, 2'd0});
        end
    endtask

    task automatic test_rtype();
        do_reset();
        go_decode(6'd0, 6'b100010);
        tick();
        n_tests++;
        if ({st, bus.alucontrol, bus.alusrca} !== {4'd6, 4'b0010, 1'b1}) begin
            n_fail++; $display("FAIL rtype_sub: got %h want %h", {st, bus.alucontrol, bus.alusrca}, {4'd6, 4'b0010, 1'b1});
        end
        tick();
        n_tests++;
        if ({st, bus.regwrite, bus.regdst} !== {4'd7, 1'b1, 2'd1}) begin
            n_fail++; $display("FAIL rtype_wb: got %h want %h", {st, bus.regwrite, bus.regdst}, {4'd7, 1'b1, 2'd1});
        end
        tick();
        go_decode(6'd0, 6'b111111);
        tick();
        tick();
        n_tests++;
        if ({st, bus.fault} !== {4'd15, 1'b1}) begin
            n_fail++; $display("FAIL rtype_bad_funct: got %h want %h", {st, bus.fault}, {4'd15, 1'b1});
        end
    endtask

    task automatic test_jump();
        do_reset();
        go_decode(OP_J, 6'd0);
        tick();
        n_tests++;
        if ({st, bus.pcen, bus.pcsrc} !== {4'd11, 1'b1, 2'd2}) begin
            n_fail++; $display("FAIL j_ex: got %h want %h", {st, bus.pcen, bus.pcsrc}, {4'd11, 1'b1, 2'd2});
        end
        do_reset();
        go_decode(OP_JAL, 6'd0);
        tick();
`ifdef MC_CTRL_JAL_EN
        n_tests++;
        if ({st, bus.regwrite, bus.regdst, bus.memtoreg, bus.pcsrc, bus.pcen} !== {4'd14, 1'b1, 2'd2, 2'd2, 2'd2, 1'b1}) begin
            n_fail++; $display("FAIL jal_ex: got %h want %h", {st, bus.regwrite, bus.regdst, bus.memtoreg, bus.pcsrc, bus.pcen},
                               {4'd14, 1'b1, 2'd2, 2'd2, 2'd2, 1'b1});
        end
`else
        n_tests++;
        if ({st, bus.fault} !== {4'd15, 1'b1}) begin
            n_fail++; $display("FAIL jal_illegal: got %h want %h", {st, bus.fault}, {4'd15, 1'b1});
        end
`endif
        do_reset();
        go_decode(6'b111111, 6'd0);
        tick();
        n_tests++;
        if ({st, bus.fault, bus.mem_req} !== {4'd15, 1'b1, 1'b0}) begin
            n_fail++; $display("FAIL op_illegal: got %h want %h", {st, bus.fault, bus.mem_req}, {4'd15, 1'b1, 1'b0});
        end
    endtask

    task automatic test_timeout();
        do_reset();
        repeat (15) tick();
        n_tests++;
        if (st !== 4'd0) begin n_fail++; $display("FAIL tmo_before: got %0d want 0", st); end
        tick();
        n_tests++;
        if ({st, bus.fault, bus.mem_req} !== {4'd15, 1'b1, 1'b0}) begin
            n_fail++; $display("FAIL tmo_fault: got %h want %h", {st, bus.fault, bus.mem_req}, {4'd15, 1'b1, 1'b0});
        end
        for (int i = 0; i < 20; i++) begin
            bus.mem_ready = i[0];
            tick();
            n_tests++;
            if ({st, bus.fault, bus.irwrite} !== {4'd15, 1'b1, 1'b0}) begin
                n_fail++; $display("FAIL tmo_sticky[%0d]: got %h want %h", i, {st, bus.fault, bus.irwrite}, {4'd15, 1'b1, 1'b0});
            end
        end
        do_reset();
        repeat (15) tick();
        bus.mem_ready = 1'b1;
        #1;
        n_tests++;
        if (bus.irwrite !== 1'b1) begin n_fail++; $display("FAIL tmo_edge_irwrite: got %b want 1", bus.irwrite); end
        tick();
        bus.mem_ready = 1'b0;
        n_tests++;
        if ({st, bus.fault} !== {4'd1, 1'b0}) begin
            n_fail++; $display("FAIL tmo_edge_ready: got %h want %h", {st, bus.fault}, {4'd1, 1'b0});
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        test_reset();
        test_reset_mid_write();
        test_lw_wait();
        test_branch();
        test_ori();
        test_rtype();
        test_jump();
        test_timeout();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout want finish");
        $fatal(1);
    end

endmodule
`default_nettype wire
